// File: rtl/tf328_pkg.sv
// Shared definitions for the TF328 fast-RAM DRAM sequencer: state encoding,
// default timing parameters and the refresh-counter width helper.
package tf328_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ROW,
      S_COLA,
      S_CAS,
      S_PRE,
      S_RCAS,
      S_RRAS
   } seqState_t;

   localparam int REFRESH_DIV_DEF = 220;
   localparam int TRP_DEF         = 2;
   localparam int TRAS_REF_DEF    = 3;

   // Bits needed to hold REFRESH_DIV-1; never narrower than one bit.
   function automatic int refCntWidth(input int div);
      return (div > 2) ? $clog2(div) : 1;
   endfunction

   localparam int REF_CNT_W = refCntWidth(REFRESH_DIV_DEF);

endpackage

// File: rtl/dram_refresh_timer.sv
// Refresh interval down-counter with a saturating 2-bit count of refreshes owed.
// 'done' pulses for one cycle when a CBR refresh completes.
module dram_refresh_timer
   import tf328_pkg::*;
#(
   parameter int REFRESH_DIV = REFRESH_DIV_DEF,
   parameter int CNT_W       = REF_CNT_W
)
(
   input  logic       CLKCPU,
   input  logic       RESET,
   input  logic       done,
   output logic [1:0] pend
);

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] r_count;
   logic [1:0]       r_pend;
   logic             w_tick;

   assign w_tick = (r_count == '0);

   always_ff @(posedge CLKCPU or negedge RESET) begin
      if (!RESET)
         r_count <= RELOAD;
      else if (w_tick)
         r_count <= RELOAD;
      else
         r_count <= r_count - 1'b1;
   end

   // A new request and a completion in the same cycle cancel each other out.
   always_ff @(posedge CLKCPU or negedge RESET) begin
      if (!RESET)
         r_pend <= 2'd0;
      else if (w_tick && !done && (r_pend != 2'd3))
         r_pend <= r_pend + 2'd1;
      else if (done && !w_tick && (r_pend != 2'd0))
         r_pend <= r_pend - 2'd1;
   end

   assign pend = r_pend;

endmodule

// File: rtl/dram_cycle_sequencer.sv
// TF328 fast-RAM sequencer: arbitrates 68EC020 cycles against CBR refresh and
// drives RAS/CAS/MUX/OE/ACK. Define DRAM_EARLY_ACK_EN for one-wait-state reads.
module dram_cycle_sequencer
   import tf328_pkg::*;
#(
   parameter int REFRESH_DIV = REFRESH_DIV_DEF,
   parameter int TRP         = TRP_DEF,
   parameter int TRAS_REF    = TRAS_REF_DEF
)
(
   input  logic       CLKCPU,
   input  logic       RESET,
   input  logic       AS20,
   input  logic       DS20,
   input  logic       RW20,
   input  logic       SEL,
   input  logic       BANK,
   input  logic [3:0] BE,
   output logic [1:0] RAS,
   output logic [3:0] CAS,
   output logic       RAM_MUX,
   output logic       RAMOE,
   output logic       ACK_N,
   output logic       BUSY,
   output logic [1:0] REF_PEND
);

   localparam int SEQ_W = (TRP > TRAS_REF) ? $clog2(TRP + 1) : $clog2(TRAS_REF + 1);
   localparam logic [SEQ_W-1:0] TRP_LOAD  = SEQ_W'(TRP - 1);
   localparam logic [SEQ_W-1:0] TRAS_LOAD = SEQ_W'(TRAS_REF - 1);

   seqState_t        r_state;
   seqState_t        w_nextState;
   logic [SEQ_W-1:0] r_cnt;
   logic [SEQ_W-1:0] w_cntNext;
   logic             w_refDone;
   logic [1:0]       w_pend;

   logic             r_bank;
   logic             r_read;
   logic [3:0]       r_be;
   logic             w_bankSel;

   logic [1:0]       r_ras;
   logic [3:0]       r_casLane;
   logic             r_casGate;
   logic             r_mux;
   logic             r_oe;
   logic             r_ack;
   logic             r_busy;

   logic [1:0]       w_ras;
   logic [3:0]       w_casLane;
   logic             w_casGate;
   logic             w_mux;
   logic             w_oe;
   logic             w_ack;

   dram_refresh_timer #(
      .REFRESH_DIV (REFRESH_DIV),
      .CNT_W       (refCntWidth(REFRESH_DIV))
   ) u_refreshTimer (
      .CLKCPU (CLKCPU),
      .RESET  (RESET),
      .done   (w_refDone),
      .pend   (w_pend)
   );

   // Strobes are registered from the next-state decode so they change glitch-free.
   always_ff @(posedge CLKCPU or negedge RESET) begin
      if (!RESET) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bank    <= 1'b0;
         r_read    <= 1'b1;
         r_be      <= 4'h0;
         r_ras     <= 2'b11;
         r_casLane <= 4'h0;
         r_casGate <= 1'b0;
         r_mux     <= 1'b1;
         r_oe      <= 1'b1;
         r_ack     <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_cntNext;
         if ((r_state == S_IDLE) && (w_nextState == S_ROW)) begin
            r_bank <= BANK;
            r_read <= RW20;
            r_be   <= BE;
         end
         r_ras     <= w_ras;
         r_casLane <= w_casLane;
         r_casGate <= w_casGate;
         r_mux     <= w_mux;
         r_oe      <= w_oe;
         r_ack     <= w_ack;
         r_busy    <= (w_nextState != S_IDLE);
      end
   end

   // Saturated refresh debt beats the CPU; otherwise the CPU wins over refresh.
   always_comb begin
      w_nextState = r_state;
      w_cntNext   = r_cnt;
      w_refDone   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_pend == 2'd3)
               w_nextState = S_RCAS;
            else if (!AS20 && SEL)
               w_nextState = S_ROW;
            else if (w_pend != 2'd0)
               w_nextState = S_RCAS;
         end
         S_ROW, S_COLA: begin
            if (AS20) begin
               w_nextState = S_PRE;
               w_cntNext   = TRP_LOAD;
            end else begin
               w_nextState = (r_state == S_ROW) ? S_COLA : S_CAS;
            end
         end
         S_CAS: begin
            if (AS20) begin
               w_nextState = S_PRE;
               w_cntNext   = TRP_LOAD;
            end
         end
         S_PRE: begin
            if (r_cnt == '0)
               w_nextState = S_IDLE;
            else
               w_cntNext = r_cnt - 1'b1;
         end
         S_RCAS: begin
            w_nextState = S_RRAS;
            w_cntNext   = TRAS_LOAD;
         end
         S_RRAS: begin
            if (r_cnt == '0) begin
               w_nextState = S_PRE;
               w_cntNext   = TRP_LOAD;
               w_refDone   = 1'b1;
            end else begin
               w_cntNext = r_cnt - 1'b1;
            end
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   // The bank is only sampled live on the IDLE->ROW transition; later states use the latch.
   always_comb begin
      w_bankSel = (r_state == S_IDLE) ? BANK : r_bank;
      w_ras     = 2'b11;
      w_casLane = 4'h0;
      w_casGate = 1'b0;
      w_mux     = 1'b1;
      w_oe      = 1'b1;
      w_ack     = 1'b1;
      case (w_nextState)
         S_ROW: begin
            w_ras[w_bankSel] = 1'b0;
         end
         S_COLA: begin
            w_ras[w_bankSel] = 1'b0;
            w_mux            = 1'b0;
`ifdef DRAM_EARLY_ACK_EN
            if (r_read)
               w_ack = 1'b0;
`endif
         end
         S_CAS: begin
            w_ras[w_bankSel] = 1'b0;
            w_mux            = 1'b0;
            w_ack            = 1'b0;
            if (r_read) begin
               w_casLane = 4'hF;
               w_oe      = 1'b0;
            end else begin
               w_casLane = r_be;
               w_casGate = 1'b1;
            end
         end
         S_RCAS: begin
            w_casLane = 4'hF;
         end
         S_RRAS: begin
            w_casLane = 4'hF;
            w_ras     = 2'b00;
         end
         default: ;
      endcase
   end

   // Write lanes follow DS20 combinationally so CAS never precedes valid write data.
   assign CAS      = ~(r_casLane & (r_casGate ? {4{~DS20}} : 4'hF));
   assign RAS      = r_ras;
   assign RAM_MUX  = r_mux;
   assign RAMOE    = r_oe;
   assign ACK_N    = r_ack;
   assign BUSY     = r_busy;
   assign REF_PEND = w_pend;

endmodule

// File: tb/tb_dram_cycle_sequencer.sv
// Directed self-checking bench for dram_cycle_sequencer (default build, REFRESH_DIV=220,
// TRP=2, TRAS_REF=3); edge numbers in comments count rising edges after reset release.
module tb_dram_cycle_sequencer;

   logic       CLKCPU = 1'b0;
   logic       RESET;
   logic       AS20;
   logic       DS20;
   logic       RW20;
   logic       SEL;
   logic       BANK;
   logic [3:0] BE;
   logic [1:0] RAS;
   logic [3:0] CAS;
   logic       RAM_MUX;
   logic       RAMOE;
   logic       ACK_N;
   logic       BUSY;
   logic [1:0] REF_PEND;

   int checks   = 0;
   int failures = 0;

   always #5 CLKCPU = ~CLKCPU;

   dram_cycle_sequencer #(
      .REFRESH_DIV (220),
      .TRP         (2),
      .TRAS_REF    (3)
   ) dut (
      .CLKCPU   (CLKCPU),
      .RESET    (RESET),
      .AS20     (AS20),
      .DS20     (DS20),
      .RW20     (RW20),
      .SEL      (SEL),
      .BANK     (BANK),
      .BE       (BE),
      .RAS      (RAS),
      .CAS      (CAS),
      .RAM_MUX  (RAM_MUX),
      .RAMOE    (RAMOE),
      .ACK_N    (ACK_N),
      .BUSY     (BUSY),
      .REF_PEND (REF_PEND)
   );

   task automatic step();
      @(posedge CLKCPU);
      #1;
   endtask

   task automatic applyStimulus(input logic as, input logic ds, input logic rw,
                                input logic sel, input logic bank, input logic [3:0] be);
      AS20 = as;
      DS20 = ds;
      RW20 = rw;
      SEL  = sel;
      BANK = bank;
      BE   = be;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int n;

      RESET = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
      step();
      step();
      checkOutput("rst_ras",  16'(RAS),      16'h3);
      checkOutput("rst_cas",  16'(CAS),      16'hF);
      checkOutput("rst_mux",  16'(RAM_MUX),  16'h1);
      checkOutput("rst_oe",   16'(RAMOE),    16'h1);
      checkOutput("rst_ack",  16'(ACK_N),    16'h1);
      checkOutput("rst_busy", 16'(BUSY),     16'h0);
      checkOutput("rst_pend", 16'(REF_PEND), 16'h0);

      // Longword read, bank 1
      RESET = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF);
      step();                                            // 1: ROW
      checkOutput("rd_row_ras",  16'(RAS),     16'h1);
      checkOutput("rd_row_mux",  16'(RAM_MUX), 16'h1);
      checkOutput("rd_row_cas",  16'(CAS),     16'hF);
      checkOutput("rd_row_busy", 16'(BUSY),    16'h1);
      step();                                            // 2: COLA
      checkOutput("rd_cola_mux", 16'(RAM_MUX), 16'h0);
      checkOutput("rd_cola_ack", 16'(ACK_N),   16'h1);
      checkOutput("rd_cola_ras", 16'(RAS),     16'h1);
      step();                                            // 3: CAS
      checkOutput("rd_cas_cas", 16'(CAS),   16'h0);
      checkOutput("rd_cas_oe",  16'(RAMOE), 16'h0);
      checkOutput("rd_cas_ack", 16'(ACK_N), 16'h0);
      step();
      step();                                            // 5: still CAS
      checkOutput("rd_hold_ack", 16'(ACK_N), 16'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF);
      step();                                            // 6: PRE
      checkOutput("rd_pre_ras",  16'(RAS),     16'h3);
      checkOutput("rd_pre_cas",  16'(CAS),     16'hF);
      checkOutput("rd_pre_oe",   16'(RAMOE),   16'h1);
      checkOutput("rd_pre_ack",  16'(ACK_N),   16'h1);
      checkOutput("rd_pre_mux",  16'(RAM_MUX), 16'h1);
      checkOutput("rd_pre_busy", 16'(BUSY),    16'h1);

      // Byte write (D[23:16]) to bank 0, requested while still precharging
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0100);
      step();                                            // 7: PRE
      checkOutput("wr_pre2_ras",  16'(RAS),  16'h3);
      checkOutput("wr_pre2_busy", 16'(BUSY), 16'h1);
      step();                                            // 8: IDLE
      checkOutput("wr_idle_busy", 16'(BUSY), 16'h0);
      step();                                            // 9: ROW
      checkOutput("wr_row_ras", 16'(RAS), 16'h2);
      step();                                            // 10: COLA
      checkOutput("wr_cola_mux", 16'(RAM_MUX), 16'h0);
      checkOutput("wr_cola_ack", 16'(ACK_N),   16'h1);
      step();                                            // 11: CAS, DS20 still high
      checkOutput("wr_cas_nods", 16'(CAS),   16'hF);
      checkOutput("wr_cas_ack",  16'(ACK_N), 16'h0);
      DS20 = 1'b0;
      #1;
      checkOutput("wr_cas_ds", 16'(CAS),   16'hB);
      checkOutput("wr_cas_oe", 16'(RAMOE), 16'h1);
      step();                                            // 12
      checkOutput("wr_cas_hold", 16'(CAS), 16'hB);
      DS20 = 1'b1;
      #1;
      checkOutput("wr_cas_dsoff", 16'(CAS), 16'hF);
      AS20 = 1'b1;
      step();                                            // 13: PRE
      step();                                            // 14: PRE
      step();                                            // 15: IDLE
      checkOutput("wr_end_busy", 16'(BUSY), 16'h0);

      // Idle refresh: RCAS at 221, 441, 661
      for (int r = 0; r < 3; r++) begin
         n = 0;
         while (!(RAS == 2'b11 && CAS == 4'h0) && n < 400) begin
            step();
            n++;
         end
         checkOutput($sformatf("ref%0d_interval", r), 16'(n), (r == 0) ? 16'd206 : 16'd214);
         checkOutput($sformatf("ref%0d_rcas_pend", r), 16'(REF_PEND), 16'h1);
         step();
         checkOutput($sformatf("ref%0d_rras_ras", r), 16'(RAS), 16'h0);
         checkOutput($sformatf("ref%0d_rras_cas", r), 16'(CAS), 16'h0);
         step();
         step();
         checkOutput($sformatf("ref%0d_rras3_ras", r), 16'(RAS), 16'h0);
         step();
         checkOutput($sformatf("ref%0d_pre_ras", r),  16'(RAS),      16'h3);
         checkOutput($sformatf("ref%0d_pre_cas", r),  16'(CAS),      16'hF);
         checkOutput($sformatf("ref%0d_pre_pend", r), 16'(REF_PEND), 16'h0);
         step();
         checkOutput($sformatf("ref%0d_pre2_busy", r), 16'(BUSY), 16'h1);
         step();
         checkOutput($sformatf("ref%0d_idle_busy", r), 16'(BUSY), 16'h0);
      end

      // Arbitration with one refresh owed: CPU goes first
      n = 0;
      while (REF_PEND != 2'd1 && n < 400) begin
         step();
         n++;
      end
      checkOutput("arb1_interval", 16'(n), 16'd213);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'hF);
      step();                                            // 881: ROW
      checkOutput("arb1_cpu_first", 16'(RAS),      16'h2);
      checkOutput("arb1_pend",      16'(REF_PEND), 16'h1);
      step();
      step();                                            // 883: CAS
      checkOutput("arb1_ack", 16'(ACK_N), 16'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF);
      step();
      step();
      step();                                            // 886: IDLE
      checkOutput("arb1_idle_busy", 16'(BUSY), 16'h0);
      step();                                            // 887: RCAS
      checkOutput("arb1_ref_ras", 16'(RAS), 16'h3);
      checkOutput("arb1_ref_cas", 16'(CAS), 16'h0);
      for (int k = 0; k < 6; k++) step();                // 893: IDLE
      checkOutput("arb1_done_pend", 16'(REF_PEND), 16'h0);

      // Saturation: hold a CPU cycle until three refreshes are owed
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF);
      step();
      step();
      step();                                            // 896: CAS
      n = 0;
      while (REF_PEND != 2'd3 && n < 1000) begin
         step();
         n++;
      end
      checkOutput("sat_wait",     16'(n),        16'd644);
      checkOutput("sat_pend",     16'(REF_PEND), 16'h3);
      checkOutput("sat_hold_ack", 16'(ACK_N),    16'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF);
      step();
      step();                                            // 1542: PRE
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'hF);
      step();                                            // 1543: IDLE
      checkOutput("sat_idle_busy", 16'(BUSY), 16'h0);
      step();                                            // 1544: RCAS despite request
      checkOutput("sat_ref_ras", 16'(RAS),   16'h3);
      checkOutput("sat_ref_cas", 16'(CAS),   16'h0);
      checkOutput("sat_ref_ack", 16'(ACK_N), 16'h1);
      for (int k = 0; k < 6; k++) step();                // 1550: IDLE
      checkOutput("sat_wait_ack",  16'(ACK_N), 16'h1);
      checkOutput("sat_wait_busy", 16'(BUSY),  16'h0);
      step();                                            // 1551: ROW
      checkOutput("sat_cpu_ras",  16'(RAS),      16'h2);
      checkOutput("sat_cpu_pend", 16'(REF_PEND), 16'h2);
      step();
      step();                                            // 1553: CAS
      checkOutput("sat_cpu_ack", 16'(ACK_N), 16'h0);

      // Asynchronous reset in the middle of CAS, with refresh debt outstanding
      #2;
      RESET = 1'b0;
      #1;
      checkOutput("mrst_ras",  16'(RAS),      16'h3);
      checkOutput("mrst_cas",  16'(CAS),      16'hF);
      checkOutput("mrst_oe",   16'(RAMOE),    16'h1);
      checkOutput("mrst_ack",  16'(ACK_N),    16'h1);
      checkOutput("mrst_mux",  16'(RAM_MUX),  16'h1);
      checkOutput("mrst_busy", 16'(BUSY),     16'h0);
      checkOutput("mrst_pend", 16'(REF_PEND), 16'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF);
      step();
      RESET = 1'b1;
      step();
      checkOutput("mrst_rel_busy", 16'(BUSY),     16'h0);
      checkOutput("mrst_rel_pend", 16'(REF_PEND), 16'h0);

      // Abort: AS20 rises during ROW
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF);
      step();
      checkOutput("ab_row_ras", 16'(RAS), 16'h1);
      AS20 = 1'b1;
      step();
      checkOutput("ab_pre_ras", 16'(RAS),   16'h3);
      checkOutput("ab_pre_cas", 16'(CAS),   16'hF);
      checkOutput("ab_pre_ack", 16'(ACK_N), 16'h1);
      step();
      checkOutput("ab_pre2_cas",  16'(CAS),   16'hF);
      checkOutput("ab_pre2_ack",  16'(ACK_N), 16'h1);
      checkOutput("ab_pre2_busy", 16'(BUSY),  16'h1);
      step();
      checkOutput("ab_idle_busy", 16'(BUSY), 16'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
